// File: rtl/chunk_streamer.sv
// chunk_streamer: accepts one WIDTH-bit word per input handshake and replays
// it as a run of CHUNK-bit lanes, one per output handshake, each extended to
// OUT_WIDTH. Lane indices wrap modulo LANES so a run may start anywhere.
// WIDTH must be a multiple of CHUNK, LANES >= 2 and OUT_WIDTH >= CHUNK.
module chunk_streamer #(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int OUT_WIDTH = 32,
    localparam int LANES    = WIDTH / CHUNK,
    localparam int IW       = $clog2(LANES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN_DATA,
    input  logic [IW-1:0]        IN_START,
    input  logic [IW-1:0]        IN_COUNT,
    input  logic                 IN_SIGNED,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OUT_WIDTH-1:0] OUT_DATA,
    output logic [IW-1:0]        OUT_INDEX,
    output logic                 OUT_LAST
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [IW:0]      rem_q,   rem_d;   // must hold LANES itself
    logic             sgn_q,   sgn_d;

    logic                        streaming;
    logic                        last;
    logic                        in_xfer;
    logic                        out_xfer;
    logic [LANES-1:0][CHUNK-1:0] lanes;
    logic [CHUNK-1:0]            lane;
    logic [OUT_WIDTH-1:0]        ext;

    assign streaming = (state_q == S_STREAM);
    assign last      = streaming && (rem_q == (IW+1)'(1));
    assign lanes     = word_q;
    assign lane      = lanes[idx_q];

    // Only the final lane frees the word register, so a new word may be taken
    // in the same cycle the last lane leaves (no bubble between words).
    assign IN_READY  = !RST && (!streaming || (OUT_READY && last));
    assign in_xfer   = IN_VALID && IN_READY;
    assign out_xfer  = streaming && OUT_READY;

    if (OUT_WIDTH > CHUNK) begin : g_ext
        assign ext = {{(OUT_WIDTH-CHUNK){sgn_q & lane[CHUNK-1]}}, lane};
    end else begin : g_noext
        assign ext = lane;
    end

    // Outputs read as zero whenever no lane is being presented.
    assign OUT_VALID = streaming;
    assign OUT_DATA  = streaming ? ext : '0;
    assign OUT_INDEX = streaming ? idx_q : '0;
    assign OUT_LAST  = last;

    // Next-state: load a word, advance to the next lane, or return to idle.
    // An input transfer while streaming can only coincide with the last lane.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        if (in_xfer) begin
            state_d = S_STREAM;
            word_d  = IN_DATA;
            idx_d   = IN_START;
            rem_d   = (IN_COUNT == '0) ? (IW+1)'(LANES) : {1'b0, IN_COUNT};
            sgn_d   = IN_SIGNED;
        end else if (out_xfer) begin
            if (last) begin
                state_d = S_IDLE;
            end else begin
                idx_d = (idx_q == IW'(LANES-1)) ? '0 : idx_q + 1'b1;
                rem_d = rem_q - 1'b1;
            end
        end
    end

    // State registers; reset aborts any run in progress immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
        end
    end

endmodule

// File: doc/chunk_streamer.md
Name: chunk_streamer

Overview:
- Parametrised successor to the combinational byte/chunk selector.
- Takes one WIDTH-bit word through a valid/ready input handshake and emits a run of CHUNK-bit lanes from it, one lane per handshake, through a valid/ready output.
- Each emitted lane is zero- or sign-extended to OUT_WIDTH.
- Sits between the memory read path and the vector/load unit, so multi-lane loads can be serialised without a separate selector per lane.

Parameters:
- WIDTH, 32: input word width; must be a multiple of CHUNK.
- CHUNK, 8: lane width in bits.
- OUT_WIDTH, 32: output width; must be >= CHUNK.
- LANES, WIDTH/CHUNK: derived; must be >= 2.
- IW, $clog2(LANES): derived lane-index width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  block can accept a word this cycle.
- IN_DATA  in  WIDTH  word to slice.
- IN_START  in  IW  first lane index; lane k = IN_DATA[k*CHUNK +: CHUNK].
- IN_COUNT  in  IW  number of lanes to emit; 0 encodes LANES.
- IN_SIGNED  in  1  1 = sign-extend, 0 = zero-extend.
- OUT_VALID  out  1  OUT_DATA holds a valid lane.
- OUT_READY  in  1  consumer accepts the lane.
- OUT_DATA  out  OUT_WIDTH  extended lane.
- OUT_INDEX  out  IW  lane index of OUT_DATA.
- OUT_LAST  out  1  current lane is the final lane of the word.

Behaviour:
- Reset: asynchronous, active-high. While RST=1 and at release:
  - state=IDLE; OUT_VALID=0; OUT_DATA=0; OUT_INDEX=0; OUT_LAST=0.
  - IN_READY=1 only after RST is low. IN_READY is 0 while RST=1.
  - Internal word, index, remaining count, and signed flag are all cleared.
- Handshakes:
  - An input transfer occurs on a rising edge with IN_VALID & IN_READY.
  - An output transfer occurs on a rising edge with OUT_VALID & OUT_READY.
- State IDLE:
  - IN_READY=1, OUT_VALID=0.
  - On an input transfer: latch IN_DATA and IN_SIGNED; index <= IN_START; remaining <= (IN_COUNT==0 ? LANES : IN_COUNT); go to STREAM.
- State STREAM:
  - OUT_VALID=1.
  - OUT_DATA = lane[index], extended by the latched signed flag: if signed, copy bit CHUNK-1 into the upper bits; otherwise fill with zeros.
  - OUT_INDEX = index.
  - OUT_LAST = (remaining==1).
- On an output transfer with OUT_LAST=0:
  - index <= (index+1) mod LANES. Wrap-around from LANES-1 to 0 is required.
  - remaining <= remaining-1.
- On an output transfer with OUT_LAST=1:
  - If IN_VALID=1 in the same cycle: load the new word and stay in STREAM, giving back-to-back words with no bubble.
  - Otherwise: go to IDLE.
- IN_READY in STREAM = OUT_READY & OUT_LAST. This is a combinational path from OUT_READY to IN_READY, and it is intentional.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_INDEX and OUT_LAST hold stable.
- OUT_VALID never drops without an output transfer.
- IN_DATA, IN_START, IN_COUNT and IN_SIGNED are sampled only on an input transfer. Later changes do not affect the lanes already in flight.
- Latency: word accepted on edge N; first lane valid after edge N (visible in cycle N+1).
- Throughput: one lane per cycle when OUT_READY is held high.
- Count semantics:
  - IN_COUNT=0 emits all LANES lanes.
  - IN_START and IN_COUNT together may exceed LANES-1; indices wrap, and no lane is emitted twice.
- OUT_WIDTH==CHUNK: no extension; IN_SIGNED has no effect.
- Reset mid-stream: the stream is aborted immediately and the remaining lanes are discarded; outputs return to their reset values asynchronously.

Test Plan:
1. RST high → OUT_VALID=0, OUT_DATA=0, IN_READY=0. Then word 0x887766F5, START=0, COUNT=0, SIGNED=0, OUT_READY=1 → 0x000000F5, 0x00000066, 0x00000077, 0x00000088 on consecutive cycles with indices 0..3; OUT_LAST on the 4th only; then IDLE.
2. Same word with SIGNED=1 → 0xFFFFFFF5, 0x00000066, 0x00000077, 0xFFFFFF88.
3. Wrap: word 0x887766F5, START=3, COUNT=2, SIGNED=0 → 0x00000088 (index 3), then 0x000000F5 (index 0, LAST).
4. Backpressure: OUT_READY low for 3 cycles on lane 1 of scenario 1 → OUT_DATA holds 0x00000066 and index 1; no lane is skipped or duplicated after release.
5. Back-to-back: second word 0x04030201 (COUNT=1) presented with IN_VALID high during the first word's LAST transfer → IN_READY=1 that cycle; next cycle OUT_DATA=0x00000001 with LAST=1 and no idle cycle.
6. RST asserted asynchronously after lane 1 of scenario 1 → OUT_VALID falls without a clock edge. After release, a new word 0x000000AA with COUNT=1 streams only 0x000000AA, and no stale lanes appear.
